// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - decoupled fetch front end: credit-limited imem requests,
// prefetch queue, RAW hold on the queue head and redirect flush.
module if_prefetch_stage #(
  parameter int XLEN = 32,
  parameter int FETCH_DEPTH = 4,
  parameter int NUM_HAZ = 3,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic [NUM_HAZ*5-1:0] haz_rd,
  output logic                 if_valid_out,
  input  logic                 if_ready_in,
  output logic [XLEN-1:0]      if_PC_out,
  output logic [XLEN-1:0]      if_NPC_out,
  output logic [31:0]          if_IR_out
);
  localparam int CW = $clog2(FETCH_DEPTH + 1);
  localparam int PW = $clog2(FETCH_DEPTH);
  localparam logic [31:0] NOOP = 32'h0000_0013;
  localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(FETCH_DEPTH);

  logic [31:0]     ir_q [FETCH_DEPTH];
  logic [XLEN-1:0] pc_q [FETCH_DEPTH];
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, outstanding, drop, drop_on_redirect;
  logic [CW+1:0]   credit;
  logic            req_fire, rsp_drop, rsp_keep, push, pop;
  logic            use_rs1, use_rs2, hazard;
  logic [31:0]     head_ir;
  logic [4:0]      rs1, rs2;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Responses still owed to a flushed path keep holding credit until they come back.
  assign credit = {2'b00, outstanding} + {2'b00, count} + {2'b00, drop};
  assign imem_req_valid = !rst && !redirect_valid && (credit < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_keep = imem_rsp_valid && (drop == '0);
  assign push     = rsp_keep && !redirect_valid && !rst;
  assign pop      = if_valid_out && if_ready_in;
  assign drop_on_redirect = drop + outstanding + CW'(req_fire) - CW'(rsp_keep) - CW'(rsp_drop);

  always_comb begin
    head_ir = ir_q[head];
    rs1 = head_ir[19:15];
    rs2 = head_ir[24:20];
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (head_ir[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
    hazard = 1'b0;
    for (int i = 0; i < NUM_HAZ; i++) begin
      if (use_rs1 && rs1 != 5'd0 && rs1 == haz_rd[5*i +: 5]) hazard = 1'b1;
      if (use_rs2 && rs2 != 5'd0 && rs2 == haz_rd[5*i +: 5]) hazard = 1'b1;
    end
  end

  always_comb begin
    if_valid_out = (count != '0) && !hazard && !redirect_valid;
    if_IR_out  = NOOP;
    if_PC_out  = '0;
    if_NPC_out = '0;
    if (if_valid_out) begin
      if_IR_out  = head_ir;
      if_PC_out  = pc_q[head];
      if_NPC_out = pc_q[head] + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ir_q[tail] <= imem_rsp_data;
      pc_q[tail] <= rsp_pc;
    end
  end

  // rsp_pc is the PC of the next kept response: kept responses are always on the
  // current, sequential path, so a running counter replaces a per-request PC FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
      rsp_pc      <= {RESET_PC[XLEN-1:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc      <= {redirect_pc[XLEN-1:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= drop_on_redirect;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      if (rsp_drop) drop <= drop - CW'(1);
      if (push) begin
        tail   <= tail + PW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - scoreboard bench: in-order memory model with epoch
// tagging predicts which instructions decode must see.
module tb_if_prefetch_stage;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOOP = 32'h0000_0013;
  localparam logic [31:0] ADD_INSN = 32'h0073_02B3;
  localparam logic [31:0] ADDI_X0 = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [14:0] haz_rd;
  logic        if_valid_out, if_ready_in;
  logic [31:0] if_PC_out, if_NPC_out, if_IR_out;

  always #5 clk = ~clk;

  if_prefetch_stage #(.XLEN(32), .FETCH_DEPTH(DEPTH), .NUM_HAZ(3), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .haz_rd(haz_rd),
    .if_valid_out(if_valid_out), .if_ready_in(if_ready_in),
    .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;

  req_t        mem_q[$];
  exp_t        exp_q[$];
  req_t        cur;
  logic        cur_on;
  int          cyc, epoch, lat, n_checks, n_pass;
  int          fires, delivered, first_fire, first_valid;
  logic        exp_addr_on, exp_first_on, prev_stall, last_valid;
  logic [31:0] exp_addr, exp_first_pc, prev_addr, last_ir;

  function automatic logic [31:0] insn(logic [31:0] a);
    if (a == 32'h300) return ADD_INSN;
    if (a == 32'h400) return ADDI_X0;
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive the memory response, let outputs settle, score, then clock.
  task automatic step();
    exp_t e;
    cur_on = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      cur = mem_q.pop_front();
      cur_on = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = insn(cur.addr);
    end
    #2;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      epoch++;
      exp_addr_on = 1'b1;
      exp_addr = 32'h0;
      prev_stall = 1'b0;
    end else begin
      if (imem_req_valid) begin
        if (exp_addr_on) begin
          check("req_addr_after_flush", imem_req_addr, exp_addr);
          exp_addr_on = 1'b0;
        end
        if (prev_stall) check("req_addr_stable", imem_req_addr, prev_addr);
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat});
        fires++;
        if (first_fire < 0) first_fire = cyc;
      end
      if (cur_on && cur.epoch == epoch && !redirect_valid)
        exp_q.push_back('{pc: cur.addr, ir: insn(cur.addr)});
      if (redirect_valid) check("valid_in_redirect", 32'(if_valid_out), 32'd0);
      if (!if_valid_out) begin
        check("idle_ir", if_IR_out, NOOP);
        check("idle_pc", if_PC_out | if_NPC_out, 32'h0);
      end else if (first_valid < 0) first_valid = cyc;
      if (if_valid_out && if_ready_in) begin
        delivered++;
        check("delivery_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pc", if_PC_out, e.pc);
          check("npc", if_NPC_out, e.pc + 32'd4);
          check("ir", if_IR_out, e.ir);
        end
        if (exp_first_on) begin
          check("first_pc_after_redirect", if_PC_out, exp_first_pc);
          exp_first_on = 1'b0;
        end
      end
      if (redirect_valid) begin
        epoch++;
        exp_q.delete();
        exp_addr_on = 1'b1;
        exp_addr = {redirect_pc[31:2], 2'b00};
        prev_stall = 1'b0;
      end
    end
    last_valid = if_valid_out;
    last_ir = if_IR_out;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect_to(logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    exp_first_on = 1'b1;
    exp_first_pc = {target[31:2], 2'b00};
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; epoch = 0; lat = 1;
    fires = 0; delivered = 0; first_fire = -1; first_valid = -1;
    exp_addr_on = 1'b0; exp_first_on = 1'b0; prev_stall = 1'b0;
    exp_addr = 0; exp_first_pc = 0; prev_addr = 0; last_valid = 0; last_ir = 0;
    imem_req_ready = 1'b1; if_ready_in = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; haz_rd = 15'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(posedge clk); #1;
    repeat (3) step();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid_out), 32'd0);
    check("rst_ir", if_IR_out, NOOP);
    check("rst_pc", if_PC_out, 32'h0);
    check("rst_npc", if_NPC_out, 32'h0);

    // Streaming at latency 1 from RESET_PC.
    rst = 1'b0;
    repeat (20) step();
    check("fetch_to_decode_latency", 32'(first_valid - first_fire), 32'd2);
    check("stream_delivered", 32'(delivered >= 15), 32'd1);

    // Decode stalled: credit limits requests to FETCH_DEPTH, then drains in order.
    if_ready_in = 1'b0;
    redirect_to(32'h200);
    fires = 0;
    repeat (20) step();
    check("fires_when_full", 32'(fires), 32'(DEPTH));
    check("req_held_when_full", 32'(imem_req_valid), 32'd0);
    delivered = 0;
    if_ready_in = 1'b1;
    repeat (20) step();
    check("drain_and_resume", 32'(delivered > DEPTH), 32'd1);

    // Latency 3 with requests in flight, redirect drops the old-path responses.
    lat = 3;
    repeat (15) step();
    redirect_to(32'h100);
    repeat (20) step();
    check("redirect_100_delivered", 32'(exp_first_on), 32'd0);

    // Redirect at latency 1 coincides with a returning response.
    lat = 1;
    repeat (10) step();
    redirect_to(32'h500);
    repeat (10) step();
    check("redirect_500_delivered", 32'(exp_first_on), 32'd0);

    // RAW hold on add x5,x6,x7 against slot 1 = x7.
    haz_rd = {5'd0, 5'd7, 5'd0};
    redirect_to(32'h300);
    repeat (5) step();
    check("haz_stall_valid_1", 32'(last_valid), 32'd0);
    check("haz_stall_ir_1", last_ir, NOOP);
    step();
    check("haz_stall_valid_2", 32'(last_valid), 32'd0);
    check("haz_stall_ir_2", last_ir, NOOP);
    haz_rd = 15'h0;
    step();
    check("haz_release_valid", 32'(last_valid), 32'd1);
    check("haz_release_ir", last_ir, ADD_INSN);
    repeat (5) step();

    // rs1 = x0 with all slots zero must not stall.
    redirect_to(32'h400);
    repeat (3) step();
    check("x0_no_stall", 32'(last_valid), 32'd1);
    check("x0_delivered", 32'(exp_first_on), 32'd0);

    // Random traffic: backpressure both sides, varying latency, sporadic redirects.
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 3);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready_in = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 32'($urandom_range(0, 255)) << 2;
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    if_ready_in = 1'b1;
    repeat (30) step();
    check("random_sb_drained", 32'(exp_q.size() <= DEPTH), 32'd1);

    // Reset with a full queue.
    if_ready_in = 1'b0;
    lat = 1;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_if_valid", 32'(if_valid_out), 32'd0);
    check("midrst_ir", if_IR_out, NOOP);
    check("midrst_pc", if_PC_out, 32'h0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd1);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    if_ready_in = 1'b1;
    repeat (15) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
